// File: rtl/addr_mode_sequencer.sv
// rtl/addr_mode_sequencer.sv - 6502 operand-fetch and effective-address sequencer
// JMP_IND_PAGE_WRAP_EN: indirect-mode pointer high byte wraps inside the pointer's page (NMOS bug)
module addr_mode_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  mode,
  input  logic [15:0] pc,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] ea,
  output logic        page_cross,
  output logic [1:0]  op_bytes,
  output logic        illegal
);

  localparam logic [3:0] M_IMPL  = 4'd0;
  localparam logic [3:0] M_ACC   = 4'd1;
  localparam logic [3:0] M_IMM   = 4'd2;
  localparam logic [3:0] M_ZPG   = 4'd3;
  localparam logic [3:0] M_ZPG_X = 4'd4;
  localparam logic [3:0] M_ZPG_Y = 4'd5;
  localparam logic [3:0] M_ABS   = 4'd6;
  localparam logic [3:0] M_ABS_X = 4'd7;
  localparam logic [3:0] M_ABS_Y = 4'd8;
  localparam logic [3:0] M_IND   = 4'd9;
  localparam logic [3:0] M_IND_X = 4'd10;
  localparam logic [3:0] M_IND_Y = 4'd11;
  localparam logic [3:0] M_REL   = 4'd12;

  // S_CAP absorbs the last read's data (it arrives the cycle after the strobe)
  typedef enum logic [2:0] {
    S_IDLE, S_RD_OP0, S_RD_OP1, S_RD_PTR0, S_RD_PTR1, S_CAP, S_FIX, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] ea_q, ea_d;
  logic        pcross_q, pcross_d;
  logic [1:0]  ob_q, ob_d;
  logic        ill_q, ill_d;

  logic [7:0]  idx;
  logic [7:0]  zpg_idx;
  logic [7:0]  zp_ptr;
  logic [15:0] full;
  logic [15:0] idx_ea;
  logic [15:0] rel_base;
  logic [15:0] rel_ea;
  logic [15:0] ptr_hi_addr;

  always_comb begin
    idx      = (mode_q == M_ZPG_X || mode_q == M_ABS_X) ? x_q : y_q;
    zpg_idx  = mem_rdata + idx;
    zp_ptr   = mem_rdata + ((mode_q == M_IND_X) ? x_q : 8'h00);
    full     = {mem_rdata, lo_q};
    idx_ea   = full + {8'h00, idx};
    rel_base = pc_q + 16'd1;
    rel_ea   = rel_base + {{8{mem_rdata[7]}}, mem_rdata};
    // Zero-page pointers always wrap within page zero; only JMP (ind) is configurable
    if (mode_q == M_IND) begin
`ifdef JMP_IND_PAGE_WRAP_EN
      ptr_hi_addr = {ptr_q[15:8], ptr_q[7:0] + 8'd1};
`else
      ptr_hi_addr = ptr_q + 16'd1;
`endif
    end else begin
      ptr_hi_addr = {8'h00, ptr_q[7:0] + 8'd1};
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pc_d     = pc_q;
    x_d      = x_q;
    y_d      = y_q;
    lo_d     = lo_q;
    ptr_d    = ptr_q;
    ea_d     = ea_q;
    pcross_d = pcross_q;
    ob_d     = ob_q;
    ill_d    = ill_q;
    mem_rd   = 1'b0;
    mem_addr = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          pc_d   = pc;
          x_d    = x;
          y_d    = y;
          case (mode)
            M_IMPL, M_ACC: begin
              ea_d = 16'h0000; pcross_d = 1'b0; ob_d = 2'd0; ill_d = 1'b0;
              state_d = S_DONE;
            end
            M_IMM: begin
              ea_d = pc; pcross_d = 1'b0; ob_d = 2'd1; ill_d = 1'b0;
              state_d = S_DONE;
            end
            M_ZPG, M_ZPG_X, M_ZPG_Y, M_ABS, M_ABS_X, M_ABS_Y,
            M_IND, M_IND_X, M_IND_Y, M_REL: state_d = S_RD_OP0;
            default: begin
              ea_d = 16'h0000; pcross_d = 1'b0; ob_d = 2'd0; ill_d = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_RD_OP0: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
        case (mode_q)
          M_ABS, M_ABS_X, M_ABS_Y, M_IND: state_d = S_RD_OP1;
          M_IND_X, M_IND_Y:               state_d = S_RD_PTR0;
          default:                        state_d = S_CAP;
        endcase
      end
      S_RD_OP1: begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + 16'd1;
        lo_d     = mem_rdata;
        state_d  = (mode_q == M_IND) ? S_RD_PTR0 : S_CAP;
      end
      S_RD_PTR0: begin
        // Pointer comes straight off the bus so the pointer reads stay back-to-back
        ptr_d    = (mode_q == M_IND) ? full : {8'h00, zp_ptr};
        mem_rd   = 1'b1;
        mem_addr = ptr_d;
        state_d  = S_RD_PTR1;
      end
      S_RD_PTR1: begin
        mem_rd   = 1'b1;
        mem_addr = ptr_hi_addr;
        lo_d     = mem_rdata;
        state_d  = S_CAP;
      end
      S_CAP: begin
        ill_d    = 1'b0;
        pcross_d = 1'b0;
        ob_d     = 2'd1;
        case (mode_q)
          M_ZPG:            ea_d = {8'h00, mem_rdata};
          M_ZPG_X, M_ZPG_Y: ea_d = {8'h00, zpg_idx};
          M_ABS, M_IND: begin
            ea_d = full;
            ob_d = 2'd2;
          end
          M_ABS_X, M_ABS_Y: begin
            ea_d     = idx_ea;
            pcross_d = (idx_ea[15:8] != mem_rdata);
            ob_d     = 2'd2;
          end
          M_IND_X: ea_d = full;
          M_IND_Y: begin
            ea_d     = idx_ea;
            pcross_d = (idx_ea[15:8] != mem_rdata);
          end
          M_REL: begin
            ea_d     = rel_ea;
            pcross_d = (rel_ea[15:8] != rel_base[15:8]);
          end
          default: begin
            ea_d = 16'h0000;
            ob_d = 2'd0;
          end
        endcase
        state_d = (pcross_d && (mode_q == M_ABS_X || mode_q == M_ABS_Y || mode_q == M_IND_Y))
                  ? S_FIX : S_DONE;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 4'd0;
      pc_q     <= 16'h0000;
      x_q      <= 8'h00;
      y_q      <= 8'h00;
      lo_q     <= 8'h00;
      ptr_q    <= 16'h0000;
      ea_q     <= 16'h0000;
      pcross_q <= 1'b0;
      ob_q     <= 2'd0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pc_q     <= pc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      lo_q     <= lo_d;
      ptr_q    <= ptr_d;
      ea_q     <= ea_d;
      pcross_q <= pcross_d;
      ob_q     <= ob_d;
      ill_q    <= ill_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign ea         = ea_q;
  assign page_cross = pcross_q;
  assign op_bytes   = ob_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// tb/tb_addr_mode_sequencer.sv - directed and randomized checks of addr_mode_sequencer
module tb_addr_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [15:0] pc = 16'h0000;
  logic [7:0]  x = 8'h00;
  logic [7:0]  y = 8'h00;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy, done, page_cross, illegal;
  logic [15:0] ea;
  logic [1:0]  op_bytes;

  addr_mode_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pc(pc), .x(x), .y(y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .ea(ea), .page_cross(page_cross),
    .op_bytes(op_bytes), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  logic       rd_seen = 1'b0;
  logic [7:0] rd_data = 8'h00;

  // Read data is returned the cycle after the strobe
  always @(negedge clk) begin
    rd_seen <= mem_rd;
    rd_data <= mem[mem_addr];
  end
  always @(posedge clk) mem_rdata <= rd_seen ? rd_data : 8'h00;

  int n_checks = 0;
  int n_pass = 0;

  int          obs_lat, obs_n;
  logic [15:0] obs_addr [0:7];
  int          obs_cyc [0:7];
  logic [15:0] obs_ea;
  logic        obs_pc, obs_ill, obs_busy_bad, obs_done_rd;
  logic [1:0]  obs_ob;

  int          exp_lat, exp_n;
  logic [15:0] exp_addr [0:3];
  logic [15:0] exp_ea;
  logic        exp_pc, exp_ill;
  logic [1:0]  exp_ob;

  task automatic run_op(input logic [3:0] m, input logic [15:0] p, input logic [7:0] xi,
                        input logic [7:0] yi, input bit busy_start, input bit no_wait);
    if (!no_wait) @(negedge clk);
    mode = m; pc = p; x = xi; y = yi; start = 1'b1;
    @(posedge clk);
    #1;
    start = busy_start;
    mode  = busy_start ? 4'd2 : 4'($urandom);
    pc = 16'($urandom); x = 8'($urandom); y = 8'($urandom);
    obs_n = 0; obs_lat = 0; obs_busy_bad = 1'b0; obs_done_rd = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && obs_n < 8) begin
        obs_addr[obs_n] = mem_addr;
        obs_cyc[obs_n]  = c;
        obs_n++;
      end
      if (busy !== 1'b1) obs_busy_bad = 1'b1;
      if (done === 1'b1) begin
        obs_lat = c; obs_ea = ea; obs_pc = page_cross; obs_ob = op_bytes;
        obs_ill = illegal; obs_done_rd = mem_rd;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Reference: evaluates each addressing mode from its definition against the bench memory
  task automatic model(input logic [3:0] m, input logic [15:0] p, input logic [7:0] xi,
                       input logic [7:0] yi);
    logic [15:0] p1, base, ptr, hia, a0, a1;
    logic [7:0]  zp, zp1, off;
    p1 = p + 16'd1;
    exp_ea = 16'h0000; exp_pc = 1'b0; exp_ill = 1'b0; exp_ob = 2'd0; exp_n = 0;
    case (m)
      4'd0, 4'd1: ;
      4'd2: begin exp_ea = p; exp_ob = 2'd1; end
      4'd3, 4'd4, 4'd5: begin
        exp_n = 1; exp_addr[0] = p; exp_ob = 2'd1;
        zp = mem[p] + ((m == 4'd4) ? xi : (m == 4'd5) ? yi : 8'h00);
        exp_ea = {8'h00, zp};
      end
      4'd6, 4'd7, 4'd8: begin
        exp_n = 2; exp_addr[0] = p; exp_addr[1] = p1; exp_ob = 2'd2;
        base = {mem[p1], mem[p]};
        exp_ea = base + ((m == 4'd7) ? {8'h00, xi} : (m == 4'd8) ? {8'h00, yi} : 16'h0000);
        exp_pc = (m != 4'd6) && (exp_ea[15:8] != base[15:8]);
      end
      4'd9: begin
        ptr = {mem[p1], mem[p]};
`ifdef JMP_IND_PAGE_WRAP_EN
        zp  = ptr[7:0] + 8'd1;
        hia = {ptr[15:8], zp};
`else
        hia = ptr + 16'd1;
`endif
        exp_n = 4; exp_addr[0] = p; exp_addr[1] = p1; exp_addr[2] = ptr; exp_addr[3] = hia;
        exp_ob = 2'd2; exp_ea = {mem[hia], mem[ptr]};
      end
      4'd10, 4'd11: begin
        zp  = mem[p] + ((m == 4'd10) ? xi : 8'h00);
        zp1 = zp + 8'd1;
        a0 = {8'h00, zp}; a1 = {8'h00, zp1};
        exp_n = 3; exp_addr[0] = p; exp_addr[1] = a0; exp_addr[2] = a1; exp_ob = 2'd1;
        base = {mem[a1], mem[a0]};
        exp_ea = base + ((m == 4'd11) ? {8'h00, yi} : 16'h0000);
        exp_pc = (m == 4'd11) && (exp_ea[15:8] != base[15:8]);
      end
      4'd12: begin
        exp_n = 1; exp_addr[0] = p; exp_ob = 2'd1;
        off = mem[p];
        exp_ea = p1 + {{8{off[7]}}, off};
        exp_pc = (exp_ea[15:8] != p1[15:8]);
      end
      default: exp_ill = 1'b1;
    endcase
    exp_lat = (exp_n == 0) ? 1 : exp_n + 2 + ((exp_pc && (m == 4'd7 || m == 4'd8 || m == 4'd11)) ? 1 : 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %b want 0", mem_rd); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got %h want 0000", mem_addr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (ea !== 16'h0000) $display("FAIL reset_ea got %h want 0000", ea); else n_pass++;
    n_checks++; if (page_cross !== 1'b0) $display("FAIL reset_page_cross got %b want 0", page_cross); else n_pass++;
    n_checks++; if (op_bytes !== 2'd0) $display("FAIL reset_op_bytes got %0d want 0", op_bytes); else n_pass++;
    n_checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", illegal); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_abs_x;
    mem[16'h8001] = 8'hF0; mem[16'h8002] = 8'h12;
    run_op(4'd7, 16'h8001, 8'h05, 8'h77, 1'b0, 1'b0);
    n_checks++; if (obs_ea !== 16'h12F5) $display("FAIL abs_x_ea got %h want 12f5", obs_ea); else n_pass++;
    n_checks++; if (obs_pc !== 1'b0) $display("FAIL abs_x_pc got %b want 0", obs_pc); else n_pass++;
    n_checks++; if (obs_lat != 4) $display("FAIL abs_x_lat got %0d want 4", obs_lat); else n_pass++;
    run_op(4'd7, 16'h8001, 8'h20, 8'h77, 1'b0, 1'b0);
    n_checks++; if (obs_ea !== 16'h1310) $display("FAIL abs_x_cross_ea got %h want 1310", obs_ea); else n_pass++;
    n_checks++; if (obs_pc !== 1'b1) $display("FAIL abs_x_cross_pc got %b want 1", obs_pc); else n_pass++;
    n_checks++; if (obs_lat != 5) $display("FAIL abs_x_cross_lat got %0d want 5", obs_lat); else n_pass++;
    n_checks++; if (obs_ob !== 2'd2) $display("FAIL abs_x_ob got %0d want 2", obs_ob); else n_pass++;
  endtask

  task automatic test_zpg_ind_x;
    mem[16'h0300] = 8'hF0;
    run_op(4'd4, 16'h0300, 8'h20, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_ea !== 16'h0010) $display("FAIL zpg_x_ea got %h want 0010", obs_ea); else n_pass++;
    n_checks++; if (obs_pc !== 1'b0) $display("FAIL zpg_x_pc got %b want 0", obs_pc); else n_pass++;
    n_checks++; if (obs_lat != 3) $display("FAIL zpg_x_lat got %0d want 3", obs_lat); else n_pass++;
    mem[16'h0310] = 8'hFE;
    run_op(4'd10, 16'h0310, 8'h01, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_n != 3) $display("FAIL ind_x_nreads got %0d want 3", obs_n); else n_pass++;
    n_checks++; if (obs_addr[1] !== 16'h00FF) $display("FAIL ind_x_ptr0 got %h want 00ff", obs_addr[1]); else n_pass++;
    n_checks++; if (obs_addr[2] !== 16'h0000) $display("FAIL ind_x_ptr1 got %h want 0000", obs_addr[2]); else n_pass++;
    n_checks++; if (obs_lat != 5) $display("FAIL ind_x_lat got %0d want 5", obs_lat); else n_pass++;
  endtask

  task automatic test_ind_y;
    mem[16'h0500] = 8'h40; mem[16'h0040] = 8'hFF; mem[16'h0041] = 8'h20;
    run_op(4'd11, 16'h0500, 8'h33, 8'h01, 1'b0, 1'b0);
    n_checks++; if (obs_ea !== 16'h2100) $display("FAIL ind_y_ea got %h want 2100", obs_ea); else n_pass++;
    n_checks++; if (obs_pc !== 1'b1) $display("FAIL ind_y_pc got %b want 1", obs_pc); else n_pass++;
    n_checks++; if (obs_lat != 6) $display("FAIL ind_y_lat got %0d want 6", obs_lat); else n_pass++;
    n_checks++; if (obs_ob !== 2'd1) $display("FAIL ind_y_ob got %0d want 1", obs_ob); else n_pass++;
  endtask

  task automatic test_indirect;
    logic [15:0] want;
    mem[16'h4000] = 8'hFF; mem[16'h4001] = 8'h30;
    mem[16'h30FF] = 8'h34; mem[16'h3000] = 8'h12; mem[16'h3100] = 8'h56;
`ifdef JMP_IND_PAGE_WRAP_EN
    want = 16'h1234;
`else
    want = 16'h5634;
`endif
    run_op(4'd9, 16'h4000, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_ea !== want) $display("FAIL indirect_ea got %h want %h", obs_ea, want); else n_pass++;
    n_checks++; if (obs_lat != 6) $display("FAIL indirect_lat got %0d want 6", obs_lat); else n_pass++;
  endtask

  task automatic test_relative;
    mem[16'h80FE] = 8'h01;
    run_op(4'd12, 16'h80FE, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_ea !== 16'h8100) $display("FAIL rel_fwd_ea got %h want 8100", obs_ea); else n_pass++;
    n_checks++; if (obs_pc !== 1'b1) $display("FAIL rel_fwd_pc got %b want 1", obs_pc); else n_pass++;
    n_checks++; if (obs_lat != 3) $display("FAIL rel_fwd_lat got %0d want 3", obs_lat); else n_pass++;
    mem[16'h80FE] = 8'h80;
    run_op(4'd12, 16'h80FE, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_ea !== 16'h807F) $display("FAIL rel_back_ea got %h want 807f", obs_ea); else n_pass++;
    n_checks++; if (obs_pc !== 1'b0) $display("FAIL rel_back_pc got %b want 0", obs_pc); else n_pass++;
    n_checks++; if (obs_lat != 3) $display("FAIL rel_back_lat got %0d want 3", obs_lat); else n_pass++;
  endtask

  task automatic test_control;
    int extra;
    run_op(4'd2, 16'h1234, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_lat != 1 || obs_n != 0) $display("FAIL imm_timing got lat=%0d reads=%0d want 1/0", obs_lat, obs_n); else n_pass++;
    n_checks++; if (obs_ea !== 16'h1234 || obs_ob !== 2'd1) $display("FAIL imm_result got ea=%h ob=%0d want 1234/1", obs_ea, obs_ob); else n_pass++;
    run_op(4'd0, 16'h5555, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_lat != 1 || obs_n != 0 || obs_ea !== 16'h0000 || obs_ob !== 2'd0)
      $display("FAIL implied got lat=%0d reads=%0d ea=%h ob=%0d want 1/0/0000/0", obs_lat, obs_n, obs_ea, obs_ob); else n_pass++;
    run_op(4'd14, 16'h5555, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++; if (obs_lat != 1 || obs_n != 0 || obs_ill !== 1'b1 || obs_ea !== 16'h0000)
      $display("FAIL illegal got lat=%0d reads=%0d ill=%b ea=%h want 1/0/1/0000", obs_lat, obs_n, obs_ill, obs_ea); else n_pass++;
    run_op(4'd7, 16'h8001, 8'h05, 8'h00, 1'b1, 1'b0);
    n_checks++; if (obs_lat != 4 || obs_ea !== 16'h12F5) $display("FAIL start_busy got lat=%0d ea=%h want 4/12f5", obs_lat, obs_ea); else n_pass++;
    extra = 0;
    repeat (4) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) extra++; end
    n_checks++; if (extra != 0) $display("FAIL start_busy_quiet got %0d active cycles want 0", extra); else n_pass++;
  endtask

  task automatic test_abort;
    int extra;
    @(negedge clk);
    mode = 4'd6; pc = 16'h8001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || done !== 1'b0)
      $display("FAIL abort got busy=%b mem_rd=%b done=%b want 0/0/0", busy, mem_rd, done); else n_pass++;
    rst = 1'b0;
    extra = 0;
    repeat (6) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) extra++; end
    n_checks++; if (extra != 0) $display("FAIL abort_quiet got %0d active cycles want 0", extra); else n_pass++;
    rst = 1'b1; start = 1'b1; mode = 4'd6;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_start got busy=%b done=%b want 0/0", busy, done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [3:0]  m;
    logic [15:0] p, prev;
    logic [7:0]  xi, yi;
    for (int i = 0; i < 8; i++) begin
      m = 4'($urandom_range(0, 15)); p = 16'($urandom); xi = 8'($urandom); yi = 8'($urandom);
      model(m, p, xi, yi);
      run_op(m, p, xi, yi, 1'b0, (i != 0));
      n_checks++; if (obs_lat != exp_lat || obs_ea !== exp_ea)
        $display("FAIL b2b_%0d mode %0d got lat=%0d ea=%h want %0d/%h", i, m, obs_lat, obs_ea, exp_lat, exp_ea); else n_pass++;
      prev = obs_ea;
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || ea !== prev)
        $display("FAIL b2b_hold_%0d got done=%b busy=%b ea=%h want 0/0/%h", i, done, busy, ea, prev); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [3:0]  m;
    logic [15:0] p;
    logic [7:0]  xi, yi;
    for (int i = 0; i < 60; i++) begin
      m = 4'($urandom_range(0, 15)); p = 16'($urandom); xi = 8'($urandom); yi = 8'($urandom);
      model(m, p, xi, yi);
      run_op(m, p, xi, yi, 1'b0, 1'b0);
      n_checks++; if (obs_lat != exp_lat) $display("FAIL rnd%0d_lat mode %0d got %0d want %0d", i, m, obs_lat, exp_lat); else n_pass++;
      n_checks++; if (obs_ea !== exp_ea) $display("FAIL rnd%0d_ea mode %0d got %h want %h", i, m, obs_ea, exp_ea); else n_pass++;
      n_checks++; if (obs_pc !== exp_pc || obs_ob !== exp_ob || obs_ill !== exp_ill)
        $display("FAIL rnd%0d_flags mode %0d got pc=%b ob=%0d ill=%b want %b/%0d/%b", i, m, obs_pc, obs_ob, obs_ill, exp_pc, exp_ob, exp_ill); else n_pass++;
      n_checks++; if (obs_n != exp_n) $display("FAIL rnd%0d_nreads mode %0d got %0d want %0d", i, m, obs_n, exp_n); else n_pass++;
      for (int k = 0; k < exp_n && k < obs_n; k++) begin
        n_checks++; if (obs_addr[k] !== exp_addr[k] || obs_cyc[k] != k + 1)
          $display("FAIL rnd%0d_read%0d mode %0d got %h@%0d want %h@%0d", i, k, m, obs_addr[k], obs_cyc[k], exp_addr[k], k + 1); else n_pass++;
      end
      n_checks++; if (obs_busy_bad !== 1'b0 || obs_done_rd !== 1'b0)
        $display("FAIL rnd%0d_ctrl mode %0d got busy_drop=%b rd_on_done=%b want 0/0", i, m, obs_busy_bad, obs_done_rd); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset;
    test_abs_x;
    test_zpg_ind_x;
    test_ind_y;
    test_indirect;
    test_relative;
    test_control;
    test_abort;
    test_back_to_back;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
